// File: rtl/osc_meter_pkg.sv
// ---------------------------------------------------------------------------
// osc_meter_pkg
// Shared definitions for the ring-oscillator frequency meter: FSM state
// encoding, state width and the warm-up length that lets the synchronizer
// and prescaler settle before edges are counted.
// ---------------------------------------------------------------------------
package osc_meter_pkg;

  localparam int STATE_W       = 2;
  localparam int WARMUP_CYCLES = 8;
  localparam int WARMUP_W      = $clog2(WARMUP_CYCLES);

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/osc_prescaler.sv
// ---------------------------------------------------------------------------
// osc_prescaler
// DIV_LOG2-bit ripple counter clocked by the oscillator. Only its MSB leaves
// this block; one MSB period equals 2^DIV_LOG2 oscillator periods. This is
// the only logic outside the wb_clk_i domain.
// Ports:
//   osc_out : oscillator output (asynchronous to the system clock)
//   rst_n   : asynchronous active-low reset
//   msb     : prescaler MSB, to be synchronized by the consumer
// ---------------------------------------------------------------------------
module osc_prescaler #(
  parameter int DIV_LOG2 = 4
) (
  input  logic osc_out,
  input  logic rst_n,
  output logic msb
);

  logic [DIV_LOG2-1:0] q;
  logic                stage0;

  // First stage toggles on every oscillator rising edge.
  always_ff @(posedge osc_out or negedge rst_n) begin
    if (!rst_n) begin
      stage0 <= 1'b0;
    end else begin
      stage0 <= ~stage0;
    end
  end

  assign q[0] = stage0;

  // Each further stage toggles on the falling edge of the previous one, so
  // the chain counts upward; each stage owns its own flop to keep one driver
  // per clocked signal.
  for (genvar i = 1; i < DIV_LOG2; i++) begin : g_stage
    logic t;

    // Ripple stage i.
    always_ff @(negedge q[i-1] or negedge rst_n) begin
      if (!rst_n) begin
        t <= 1'b0;
      end else begin
        t <= ~t;
      end
    end

    assign q[i] = t;
  end

  assign msb = q[DIV_LOG2-1];

endmodule

// File: rtl/osc_freq_meter.sv
// ---------------------------------------------------------------------------
// osc_freq_meter
// Enables the ring oscillator, counts prescaled oscillator edges over a
// programmable window of wb_clk_i cycles and reports the saturating count.
// Ports:
//   wb_clk_i : system clock (sole clock of the measurement logic)
//   rst_n    : asynchronous active-low reset
//   osc_out  : gated oscillator output, asynchronous to wb_clk_i
//   osc_en   : oscillator enable (high in WARMUP and GATE)
//   start    : single-cycle measurement request, honoured only in IDLE
//   window   : gate length in wb_clk_i cycles, sampled on accepted start
//   busy     : high from the cycle after accepted start through done
//   done     : one-cycle result-valid pulse
//   count    : last result, held until the next done
//   overflow : last result saturated
// ---------------------------------------------------------------------------
module osc_freq_meter
  import osc_meter_pkg::*;
#(
  parameter int WINDOW_W = 16,
  parameter int CNT_W    = 20,
  parameter int DIV_LOG2 = 4
) (
  input  logic                wb_clk_i,
  input  logic                rst_n,
  input  logic                osc_out,
  output logic                osc_en,
  input  logic                start,
  input  logic [WINDOW_W-1:0] window,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    count,
  output logic                overflow
);

  localparam logic [WINDOW_W-1:0] WIN_ONE   = {{(WINDOW_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WARMUP_W-1:0] WARM_ONE  = {{(WARMUP_W-1){1'b0}}, 1'b1};
  localparam logic [WARMUP_W-1:0] WARM_LAST = WARMUP_W'(WARMUP_CYCLES - 1);

  state_t              state;
  logic [WINDOW_W-1:0] win_cnt;
  logic [WARMUP_W-1:0] warm_cnt;
  logic [CNT_W-1:0]    acc;
  logic                acc_ovf;
  logic [CNT_W-1:0]    acc_next;
  logic                ovf_next;
  logic                osc_msb;
  logic [2:0]          sync;
  logic                msb_rise;

  osc_prescaler #(
    .DIV_LOG2 (DIV_LOG2)
  ) u_prescaler (
    .osc_out (osc_out),
    .rst_n   (rst_n),
    .msb     (osc_msb)
  );

  // Two-flop synchronizer for the prescaler MSB plus a third flop for edge detect.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 3'b000;
    end else begin
      sync <= {sync[1:0], osc_msb};
    end
  end

  assign msb_rise = sync[1] & ~sync[2];

  // Saturating accumulator update; overflow is sticky once an increment is lost.
  always_comb begin
    acc_next = acc;
    ovf_next = acc_ovf;
    if (msb_rise) begin
      if (acc == {CNT_W{1'b1}}) begin
        ovf_next = 1'b1;
      end else begin
        acc_next = acc + CNT_ONE;
      end
    end else begin
      acc_next = acc;
      ovf_next = acc_ovf;
    end
  end

  // Measurement FSM with registered outputs. The result is loaded from the
  // next-accumulator value so an edge seen in the last GATE cycle counts.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      win_cnt  <= '0;
      warm_cnt <= '0;
      acc      <= '0;
      acc_ovf  <= 1'b0;
      osc_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (window != '0) begin
              state    <= WARMUP;
              win_cnt  <= window;
              warm_cnt <= '0;
              acc      <= '0;
              acc_ovf  <= 1'b0;
              osc_en   <= 1'b1;
            end else begin
              // Empty window: report zero without touching the oscillator.
              state    <= DONE;
              done     <= 1'b1;
              count    <= '0;
              overflow <= 1'b0;
            end
          end else begin
            busy   <= 1'b0;
            osc_en <= 1'b0;
          end
        end
        WARMUP: begin
          warm_cnt <= warm_cnt + WARM_ONE;
          if (warm_cnt == WARM_LAST) begin
            state <= GATE;
          end else begin
            state <= WARMUP;
          end
        end
        GATE: begin
          acc     <= acc_next;
          acc_ovf <= ovf_next;
          win_cnt <= win_cnt - WIN_ONE;
          if (win_cnt == WIN_ONE) begin
            state    <= DONE;
            done     <= 1'b1;
            osc_en   <= 1'b0;
            count    <= acc_next;
            overflow <= ovf_next;
          end else begin
            state <= GATE;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done   <= 1'b0;
          busy   <= 1'b0;
          osc_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
